// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: multi-word unsigned add through one shared external 16-bit adder,
// one word per clock, LSW first, with the carry chained through a register.
`default_nettype none

module wide_add_sequencer #(
  parameter int NUM_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      start,
  input  logic [16*NUM_WORDS-1:0]   a_in,
  input  logic [16*NUM_WORDS-1:0]   b_in,
  input  logic                      carry_in,
  output logic [15:0]               add_a,
  output logic [15:0]               add_b,
  output logic                      add_cin,
  input  logic [15:0]               add_sum,
  input  logic                      add_cout,
  output logic                      busy,
  output logic                      done,
  output logic [16*NUM_WORDS-1:0]   result,
  output logic                      overflow
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                      state_q;
  logic [IDX_W-1:0]            idx_q;
  logic [IDX_W-1:0]            idx_d;
  logic [NUM_WORDS-1:0][15:0]  a_q;
  logic [NUM_WORDS-1:0][15:0]  b_q;
  logic [NUM_WORDS-1:0][15:0]  result_q;
  logic [15:0]                 add_a_q;
  logic [15:0]                 add_b_q;
  logic                        add_cin_q;
  logic                        overflow_q;
  logic                        busy_q;
  logic                        done_q;

  assign idx_d = idx_q + 1'b1;

  // add_cin_q doubles as the inter-word carry register: it always holds the carry
  // into the word currently presented to the adder, and is zero outside ADD.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      add_cin_q  <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q        <= a_in;
            b_q        <= b_in;
            idx_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b1;
            add_a_q    <= a_in[15:0];
            add_b_q    <= b_in[15:0];
            add_cin_q  <= carry_in;
            state_q    <= S_ADD;
          end
        end
        S_ADD: begin
          result_q[idx_q] <= add_sum;
          if (idx_q == LAST_IDX) begin
            overflow_q <= add_cout;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            add_a_q    <= '0;
            add_b_q    <= '0;
            add_cin_q  <= 1'b0;
            state_q    <= S_DONE;
          end else begin
            idx_q     <= idx_d;
            add_a_q   <= a_q[idx_d];
            add_b_q   <= b_q[idx_d];
            add_cin_q <= add_cout;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign add_a    = add_a_q;
  assign add_b    = add_b_q;
  assign add_cin  = add_cin_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: directed cases plus a random regression
// compared against a plain-arithmetic reference sum.
`default_nettype none

module tb_wide_add_sequencer;

  localparam int NW = 4;
  localparam int W  = 16 * NW;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          carry_in;
  logic [15:0]   add_a;
  logic [15:0]   add_b;
  logic          add_cin;
  logic [15:0]   add_sum;
  logic          add_cout;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          overflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // The shared 16-bit combinational ripple adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);

  wide_add_sequencer #(.NUM_WORDS(NW)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .carry_in (carry_in),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({busy, done, overflow, add_cin, add_a, add_b, result});
  endfunction

  // One full operation with cycle-by-cycle checks; inputs are scrambled right after capture.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        output logic [W-1:0] res, output logic ovf);
    logic [W:0]   exp_sum;
    logic         c;
    logic [16:0]  s;
    int           busy_n;
    int           done_n;
    exp_sum  = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    a_in     = a;
    b_in     = b;
    carry_in = cin;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    a_in     = {$urandom, $urandom};
    b_in     = {$urandom, $urandom};
    carry_in = ~cin;
    c        = cin;
    busy_n   = 0;
    done_n   = 0;
    for (int i = 0; i < NW; i++) begin
      check("add_a", 128'(add_a), 128'(a[16*i +: 16]));
      check("add_b", 128'(add_b), 128'(b[16*i +: 16]));
      check("add_cin", 128'(add_cin), 128'(c));
      s = {1'b0, a[16*i +: 16]} + {1'b0, b[16*i +: 16]} + 17'(c);
      c = s[16];
      if (busy) busy_n++;
      if (done) done_n++;
      tick();
    end
    check("busy_cycles", 128'(busy_n), 128'(NW));
    check("early_done", 128'(done_n), 128'(0));
    check("done_pulse", 128'(done), 128'(1));
    check("busy_in_done", 128'(busy), 128'(0));
    check("result", 128'(result), 128'(exp_sum[W-1:0]));
    check("overflow", 128'(overflow), 128'(exp_sum[W]));
    res = result;
    ovf = overflow;
    tick();
    check("done_one_cycle", 128'(done), 128'(0));
    check("result_held", 128'(result), 128'(exp_sum[W-1:0]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r;
    logic         o;
    logic [W-1:0] a1, b1, a3, b3;
    logic [W:0]   e1, e3;
    int           done_at[$];
    int           busy_seen;
    int           done_seen;

    n_rst    = 1'b0;
    start    = 1'b0;
    a_in     = '0;
    b_in     = '0;
    carry_in = 1'b0;
    tick();
    tick();
    check("reset_outputs", all_outs(), 128'(0));
    n_rst = 1'b1;
    tick();
    check("idle_outputs", all_outs(), 128'(0));

    // Small add
    run_op(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 1'b0, r, o);
    check("t2_result", 128'(r), 128'h3);
    check("t2_overflow", 128'(o), 128'(0));

    // Carry ripples through every word
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, r, o);
    check("t3_result", 128'(r), 128'h0);
    check("t3_overflow", 128'(o), 128'(1));

    // Carry out of word 0 into word 1
    run_op(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, r, o);
    check("t4_result", 128'(r), 128'h0000_0000_0001_0000);
    check("t4_overflow", 128'(o), 128'(0));

    // start pulses during ADD and DONE are ignored
    a1 = {$urandom, $urandom};
    b1 = {$urandom, $urandom};
    e1 = {1'b0, a1} + {1'b0, b1};
    a_in = a1; b_in = b1; carry_in = 1'b0; start = 1'b1;
    tick();
    for (int i = 0; i < NW; i++) begin
      start = (i == 1 || i == 2);
      a_in  = ~a1;
      b_in  = ~b1;
      tick();
    end
    check("t5_done", 128'(done), 128'(1));
    check("t5_result", 128'(result), 128'(e1[W-1:0]));
    check("t5_overflow", 128'(overflow), 128'(e1[W]));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_no_accept_from_done", 128'(busy), 128'(0));
    tick();
    check("t5_still_idle", 128'(busy), 128'(0));
    check("t5_result_kept", 128'(result), 128'(e1[W-1:0]));

    // start held high: back-to-back ops every NW+2 cycles
    a3 = {$urandom, $urandom};
    b3 = {$urandom, $urandom};
    e3 = {1'b0, a3} + {1'b0, b3} + (W+1)'(1);
    a_in = a3; b_in = b3; carry_in = 1'b1; start = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (done) begin
        done_at.push_back(j);
        check("t5b_result", 128'(result), 128'(e3[W-1:0]));
      end
    end
    start = 1'b0;
    check("t5b_done_count", 128'(done_at.size()), 128'(3));
    if (done_at.size() >= 3) begin
      check("t5b_first_done", 128'(done_at[0]), 128'(NW));
      check("t5b_period1", 128'(done_at[1] - done_at[0]), 128'(NW + 2));
      check("t5b_period2", 128'(done_at[2] - done_at[1]), 128'(NW + 2));
    end
    for (int j = 0; j < 8; j++) tick();

    // Reset in the middle of ADD aborts the op
    a_in = 64'hFFFF_FFFF_FFFF_FFFF; b_in = 64'h1234_5678_9ABC_DEF0; carry_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    n_rst = 1'b0;
    #1;
    check("midrun_reset_outputs", all_outs(), 128'(0));
    tick();
    n_rst = 1'b1;
    busy_seen = 0;
    done_seen = 0;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (busy) busy_seen++;
      if (done) done_seen++;
    end
    check("post_reset_no_busy", 128'(busy_seen), 128'(0));
    check("post_reset_no_done", 128'(done_seen), 128'(0));
    check("post_reset_result", 128'(result), 128'(0));

    // Random regression
    for (int k = 0; k < 1000; k++) begin
      logic [W-1:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rb = ~ra;
      run_op(ra, rb, 1'($urandom_range(0, 1)), r, o);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
